// File: rtl/spi_reg_bank.sv
// SPI-facing register bank: a command byte selects a register, then data bytes are written to it or read back from it.
// Define SPI_REG_BANK_AUTOINC_EN to make the address auto-increment (with wrap) for burst access.
//
// state  | meaning
// S_IDLE | after reset, waiting for transaction_begin; byte events ignored
// S_CMD  | next byte event is the command byte (op + address)
// S_DATA | byte events are data bytes for the latched address
module spi_reg_bank #(
    parameter int                    NUM_REGS     = 8,
    parameter logic [7:0]            FW_VERSION   = 8'hC3,
    parameter logic [NUM_REGS-1:0]   RO_MASK      = {NUM_REGS{1'b0}},
    parameter logic [NUM_REGS*8-1:0] RESET_VALUES = {NUM_REGS*8{1'b0}}
) (
    input  logic                    clk_core,
    input  logic                    reset,
    input  logic                    transaction_begin,
    input  logic                    rx_byte_available,
    input  logic [7:0]              rx_byte,
    output logic [7:0]              tx_byte,
    input  logic [NUM_REGS*8-1:0]   reg_in,
    output logic [NUM_REGS*8-1:0]   reg_out,
    output logic [NUM_REGS-1:0]     wr_strobe
);

    typedef enum logic [1:0] {S_IDLE, S_CMD, S_DATA} state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [1:0]              r_hist;
    logic                    r_op;
    logic [6:0]              r_addr;
    logic [7:0]              r_tx;
    logic [NUM_REGS*8-1:0]   r_regs;
    logic [NUM_REGS-1:0]     r_strobe;

    logic                    w_evt;
    logic                    w_take;
    logic                    w_data_wr;
    logic [6:0]              w_addr_next;
    logic [NUM_REGS-1:0]     w_wr_sel;
    logic [NUM_REGS*8-1:0]   w_regs_next;

    function automatic logic [7:0] read_reg(input logic [6:0] a,
                                            input logic [NUM_REGS*8-1:0] regs,
                                            input logic [NUM_REGS*8-1:0] ro_vals);
        logic [7:0] v;
        v = 8'h00;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (a == 7'(i)) begin
                if (i == 0)
                    v = FW_VERSION;
                else if (RO_MASK[i])
                    v = ro_vals[i*8 +: 8];
                else
                    v = regs[i*8 +: 8];
            end
        end
        return v;
    endfunction

    // Rising edge of the level, seen one clock late, gives one event per byte.
    assign w_evt  = (r_hist == 2'b01);
    assign w_take = w_evt && !transaction_begin;
    assign w_data_wr = w_take && (r_state == S_DATA) && r_op;

`ifdef SPI_REG_BANK_AUTOINC_EN
    assign w_addr_next = (r_addr == 7'(NUM_REGS - 1)) ? 7'd0 : r_addr + 7'd1;
`else
    assign w_addr_next = r_addr;
`endif

    always_comb begin
        w_wr_sel = '0;
        for (int i = 0; i < NUM_REGS; i++)
            w_wr_sel[i] = (r_addr == 7'(i)) && (i != 0) && !RO_MASK[i];
    end

    // Forward the byte being written so a same-edge readback sees the new value.
    always_comb begin
        w_regs_next = r_regs;
        if (w_data_wr) begin
            for (int i = 0; i < NUM_REGS; i++)
                if (w_wr_sel[i])
                    w_regs_next[i*8 +: 8] = rx_byte;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (transaction_begin)
            w_state_next = S_CMD;
        else if (w_evt && r_state == S_CMD)
            w_state_next = S_DATA;
    end

    always_ff @(posedge clk_core or posedge reset) begin
        if (reset)
            r_state <= S_IDLE;
        else
            r_state <= w_state_next;
    end

    always_ff @(posedge clk_core or posedge reset) begin
        if (reset) begin
            r_hist   <= 2'b00;
            r_op     <= 1'b0;
            r_addr   <= 7'd0;
            r_tx     <= 8'h00;
            r_regs   <= RESET_VALUES;
            r_strobe <= '0;
        end else begin
            r_hist   <= {r_hist[0], rx_byte_available};
            r_strobe <= '0;
            r_regs   <= w_regs_next;
            if (transaction_begin) begin
                r_tx <= 8'h00;
            end else if (w_take && r_state == S_CMD) begin
                r_op   <= rx_byte[7];
                r_addr <= rx_byte[6:0];
                if (!rx_byte[7])
                    r_tx <= read_reg(rx_byte[6:0], r_regs, reg_in);
            end else if (w_take && r_state == S_DATA) begin
                if (r_op)
                    r_strobe <= w_wr_sel;
                r_addr <= w_addr_next;
                r_tx   <= read_reg(w_addr_next, w_regs_next, reg_in);
            end
        end
    end

    assign tx_byte   = r_tx;
    assign reg_out   = r_regs;
    assign wr_strobe = r_strobe;

endmodule

// File: tb/tb_spi_reg_bank.sv
// Self-checking bench for spi_reg_bank: a behavioural model feeds expected tx/register values and write strobes into scoreboard queues.
// Expectations follow SPI_REG_BANK_AUTOINC_EN when it is defined for the build.
module tb_spi_reg_bank;

    localparam int          NR     = 8;
    localparam logic [7:0]  RO_M   = 8'b0000_0100;
    localparam logic [63:0] RV     = 64'h8070_6050_4030_2010;
    localparam logic [63:0] REG_IN = 64'hDEAD_BEEF_01A5_CAFE;

    logic        clk;
    logic        reset;
    logic        transaction_begin;
    logic        rx_byte_available;
    logic [7:0]  rx_byte;
    logic [7:0]  tx_byte;
    logic [63:0] reg_in;
    logic [63:0] reg_out;
    logic [7:0]  wr_strobe;

    int checks = 0;
    int errors = 0;

    logic [7:0]  exp_tx_q[$];
    logic [63:0] exp_reg_q[$];
    int          exp_strb_q[$];
    int          obs_strb_q[$];

    logic [7:0] m_regs[NR];
    int         m_state;
    bit         m_op;
    int         m_addr;
    logic [7:0] m_tx;

    spi_reg_bank #(
        .NUM_REGS(NR), .FW_VERSION(8'hC3), .RO_MASK(RO_M), .RESET_VALUES(RV)
    ) dut (
        .clk_core(clk), .reset(reset), .transaction_begin(transaction_begin),
        .rx_byte_available(rx_byte_available), .rx_byte(rx_byte), .tx_byte(tx_byte),
        .reg_in(reg_in), .reg_out(reg_out), .wr_strobe(wr_strobe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk)
        for (int i = 0; i < NR; i++)
            if (wr_strobe[i] === 1'b1) obs_strb_q.push_back(i);

    function automatic logic [7:0] m_read(int a);
        if (a == 0) return 8'hC3;
        if (a >= NR) return 8'h00;
        if (RO_M[a]) return REG_IN[a*8 +: 8];
        return m_regs[a];
    endfunction

    function automatic logic [63:0] m_pack();
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < NR; i++) v[i*8 +: 8] = m_regs[i];
        return v;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < NR; i++) m_regs[i] = RV[i*8 +: 8];
        m_state = 0; m_op = 1'b0; m_addr = 0; m_tx = 8'h00;
    endtask

    task automatic model_byte(input logic [7:0] b);
        if (m_state == 1) begin
            m_op   = b[7];
            m_addr = int'(b[6:0]);
            if (!m_op) m_tx = m_read(m_addr);
            m_state = 2;
        end else if (m_state == 2) begin
            if (m_op && m_addr >= 1 && m_addr < NR && !RO_M[m_addr]) begin
                m_regs[m_addr] = b;
                exp_strb_q.push_back(m_addr);
            end
`ifdef SPI_REG_BANK_AUTOINC_EN
            m_addr = (m_addr == NR - 1) ? 0 : ((m_addr + 1) % 128);
`endif
            m_tx = m_read(m_addr);
        end
    endtask

    task automatic pulse_begin();
        logic [7:0] e;
        @(posedge clk) #1;
        transaction_begin = 1'b1;
        @(posedge clk) #1;
        transaction_begin = 1'b0;
        m_state = 1; m_tx = 8'h00;
        exp_tx_q.push_back(m_tx);
        @(negedge clk);
        e = exp_tx_q.pop_front();
        checks++;
        if (tx_byte !== e) begin
            errors++; $display("FAIL begin_tx: tx_byte %h, expected %h", tx_byte, e);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit with_begin);
        logic [7:0]  e_tx;
        logic [63:0] e_reg;
        bit          ok;
        @(posedge clk) #1;
        rx_byte = b; rx_byte_available = 1'b1;
        @(posedge clk) #1;
        checks++;
        if (tx_byte !== m_tx) begin
            errors++; $display("FAIL tx_early byte %h: tx_byte %h before its edge, expected %h", b, tx_byte, m_tx);
        end
        if (with_begin) transaction_begin = 1'b1;
        @(posedge clk) #1;
        transaction_begin = 1'b0;
        if (with_begin) begin m_state = 1; m_tx = 8'h00; end
        else model_byte(b);
        exp_tx_q.push_back(m_tx);
        exp_reg_q.push_back(m_pack());
        @(negedge clk);
        e_tx  = exp_tx_q.pop_front();
        e_reg = exp_reg_q.pop_front();
        checks++;
        if (tx_byte !== e_tx) begin
            errors++; $display("FAIL tx byte %h: tx_byte %h, expected %h", b, tx_byte, e_tx);
        end
        checks++;
        if (reg_out !== e_reg) begin
            errors++; $display("FAIL reg_out byte %h: reg_out %h, expected %h", b, reg_out, e_reg);
        end
        @(posedge clk) #1;
        rx_byte_available = 1'b0;
        repeat (2) @(posedge clk);
        ok = (obs_strb_q.size() == exp_strb_q.size());
        if (ok)
            for (int i = 0; i < exp_strb_q.size(); i++)
                if (obs_strb_q[i] != exp_strb_q[i]) ok = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL wr_strobe byte %h: %0d pulses seen (first %0d), expected %0d (first %0d)", b,
                     obs_strb_q.size(), (obs_strb_q.size() > 0) ? obs_strb_q[0] : -1,
                     exp_strb_q.size(), (exp_strb_q.size() > 0) ? exp_strb_q[0] : -1);
        end
        obs_strb_q.delete();
        exp_strb_q.delete();
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if (tx_byte !== 8'h00) begin errors++; $display("FAIL reset_tx: %h, expected 00", tx_byte); end
        checks++;
        if (reg_out !== RV) begin errors++; $display("FAIL reset_regs: %h, expected %h", reg_out, RV); end
        checks++;
        if (wr_strobe !== 8'h00) begin errors++; $display("FAIL reset_strobe: %h, expected 00", wr_strobe); end
        @(posedge clk) #1;
        reset = 1'b0;
        // no transaction_begin yet: these bytes must be ignored
        send_byte(8'h00, 1'b0);
        send_byte(8'h81, 1'b0);
    endtask

    task automatic test_fw_read();
        pulse_begin();
        send_byte(8'h00, 1'b0);
    endtask

    task automatic test_write_read();
        pulse_begin(); send_byte(8'h81, 1'b0); send_byte(8'h5A, 1'b0);
        pulse_begin(); send_byte(8'h01, 1'b0);
        pulse_begin(); send_byte(8'h83, 1'b0); send_byte(8'h44, 1'b0);
        pulse_begin(); send_byte(8'h80, 1'b0); send_byte(8'h77, 1'b0);
        pulse_begin(); send_byte(8'h00, 1'b0);
    endtask

    task automatic test_burst();
        pulse_begin();
        send_byte(8'h86, 1'b0); send_byte(8'h11, 1'b0); send_byte(8'h22, 1'b0); send_byte(8'h33, 1'b0);
        pulse_begin();
        send_byte(8'h05, 1'b0); send_byte(8'h00, 1'b0); send_byte(8'h00, 1'b0); send_byte(8'h00, 1'b0);
    endtask

    task automatic test_read_only();
        pulse_begin(); send_byte(8'h82, 1'b0); send_byte(8'hFF, 1'b0);
        pulse_begin(); send_byte(8'h02, 1'b0);
        pulse_begin(); send_byte(8'h7F, 1'b0); send_byte(8'h00, 1'b0);
        pulse_begin(); send_byte(8'h09, 1'b0);
    endtask

    task automatic test_coincident();
        pulse_begin();
        send_byte(8'h81, 1'b0);
        send_byte(8'h99, 1'b1);
        send_byte(8'h01, 1'b0);
    endtask

    task automatic test_reset_abort();
        pulse_begin();
        send_byte(8'h83, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        m_reset();
        checks++;
        if (reg_out !== RV) begin errors++; $display("FAIL abort_regs: %h, expected %h", reg_out, RV); end
        checks++;
        if (tx_byte !== 8'h00) begin errors++; $display("FAIL abort_tx: %h, expected 00", tx_byte); end
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        send_byte(8'h99, 1'b0);
        pulse_begin(); send_byte(8'h03, 1'b0);
    endtask

    initial begin
        reset = 1'b1; transaction_begin = 1'b0; rx_byte_available = 1'b0;
        rx_byte = 8'h00; reg_in = REG_IN;
        m_reset();
        test_reset();
        test_fw_read();
        test_write_read();
        test_burst();
        test_read_only();
        test_coincident();
        test_reset_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1);
    end

endmodule
